serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer that produces a WIDTH-bit sum using one full-adder cell, built from two half_adder instances, reused over WIDTH clock cycles. Operands are accepted on a valid/ready input handshake and shifted through the cell LSB-first, with the carry kept in a flop between cycles. The result is presented on a valid/ready output handshake. This is the codebase's small-area alternative to a parallel ripple adder.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32
CNT_W, $clog2(WIDTH), width of the internal bit counter; derived, never overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand bundle (a, b, cin) is valid
in_ready  output  1  block accepts operands; high only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  sum and cout are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered result
cout  output  1  carry-out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, counter=0, carry flop=0, operand shift registers=0.
- States: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- IDLE: in_ready=1.
  - On the edge where in_valid&in_ready: latch a, b into shift registers, carry<=cin, counter<=0, go to SHIFT.
  - in_valid low: stay in IDLE.
- SHIFT: in_ready=0, out_valid=0. On each edge:
  - Cell computes s,c from (a_sr[0], b_sr[0], carry).
  - Result register shifts right with s inserted at MSB.
  - a_sr and b_sr shift right; carry<=c; counter increments.
  - On the edge where counter==WIDTH-1: go to DONE. Result is now LSB-aligned; cout<=c.
- DONE: out_valid=1; sum and cout held stable. On out_valid&out_ready: go to IDLE and drop out_valid on that edge.
- Latency: input handshake at edge k; out_valid high after edge k+WIDTH. Throughput is one add per WIDTH+2 cycles minimum (IDLE and DONE each take ≥1 cycle).
- Boundaries:
  - in_valid while not in IDLE: ignored, no handshake, operands not sampled.
  - Operand changes during SHIFT: no effect.
  - out_ready held high in DONE: exactly one cycle in DONE.
  - out_ready low: stay in DONE indefinitely with outputs frozen.
  - out_ready while not in DONE: no effect.
  - rst mid-SHIFT or mid-DONE: immediate return to reset values; a partial result is never presented.
  - Overflow: sum wraps modulo 2^WIDTH; the true bit WIDTH appears on cout.
- sum and cout are registered; no combinational path from inputs to outputs. in_ready is decoded from state only.

Decomposition:
- Shared package: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- Sub-module serial_fa_cell: a full adder made of two half_adder instances plus an OR of their carries. Combinational, ports (s, co, x, y, ci). This is the only instantiated child.
- All sequencing, counter and shift logic stays in serial_add_ctrl.

Test Plan:
- WIDTH=8: a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid 8 cycles after handshake, sum=0x10, cout=0, in_ready back to 1 one cycle later.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: a=0xA5, b=0x5A, out_ready=0 for 5 cycles in DONE -> sum=0xFF, cout=0 held with out_valid=1 and in_ready=0 throughout; out_ready pulse -> IDLE next edge.
- Busy rejection: after accepting a=0x03, b=0x04, drive in_valid with a=0xFF, b=0xFF during SHIFT -> no handshake; result sum=0x07, cout=0.
- Reset mid-op: assert rst 3 cycles into SHIFT -> all outputs at reset values immediately; after release, in_ready=1 and a new add a=0x80, b=0x80 gives sum=0x00, cout=1.
- Exhaustive sweep at WIDTH=4, all a, b, cin combinations -> {cout, sum} equals a+b+cin for every case.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single full-adder cell reused every cycle by the serial adder,
// composed of two half adders with their carries ORed together.

module half_adder (
   output logic s,
   output logic co,
   input  logic x,
   input  logic y
);
   assign s  = x ^ y;
   assign co = x & y;
endmodule

module serial_fa_cell (
   output logic s,
   output logic co,
   input  logic x,
   input  logic y,
   input  logic ci
);
   logic p;
   logic g0;
   logic g1;

   half_adder u_ha0 (
      .s  (p),
      .co (g0),
      .x  (x),
      .y  (y)
   );

   half_adder u_ha1 (
      .s  (s),
      .co (g1),
      .x  (p),
      .y  (ci)
   );

   assign co = g0 | g1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH
// cycles, operands in LSB-first, carry kept in a flop between bits.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned      CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_s;
   logic             fa_c;

   serial_fa_cell u_cell (
      .s  (fa_s),
      .co (fa_c),
      .x  (a_sr_q[0]),
      .y  (b_sr_q[0]),
      .ci (carry_q)
   );

   // State, datapath and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   // Next-state and datapath update; each SHIFT edge consumes one bit.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the first sum bit.
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               cout_d  = fa_c;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = res_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: 8-bit scenarios plus a 4-bit sweep.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst;

   logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
   logic [3:0] a4, b4, sum4;

   int unsigned n_tests;
   int unsigned n_fail;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .cin       (cin8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .sum       (sum8),
      .cout      (cout8)
   );

   serial_add_ctrl #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
      .cin       (cin4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .sum       (sum4),
      .cout      (cout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Handshake one operand bundle into the 8-bit DUT; returns on the negedge after the accepting edge.
   task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      int unsigned n = 0;
      while (!in_ready8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("start8_ready", in_ready8, 1);
      a8 = av; b8 = bv; cin8 = ci; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
   endtask

   task automatic wait8(output int unsigned n);
      n = 0;
      while (!out_valid8 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic ci);
      int unsigned n = 0;
      while (!in_ready4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      a4 = av; b4 = bv; cin4 = ci; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
   endtask

   task automatic wait4();
      int unsigned n = 0;
      while (!out_valid4 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int unsigned lat;
      logic [4:0]  e4;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;

      @(negedge clk);
      chk("rst_in_ready", in_ready8, 1);
      chk("rst_out_valid", out_valid8, 0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic add with latency and return to IDLE.
      start8(8'h0F, 8'h01, 1'b0);
      wait8(lat);
      chk("t1_latency", lat, 8);
      chk("t1_sum", sum8, 8'h10);
      chk("t1_cout", cout8, 0);
      chk("t1_in_ready_busy", in_ready8, 0);
      @(negedge clk);
      chk("t1_out_valid_drop", out_valid8, 0);
      chk("t1_in_ready_back", in_ready8, 1);

      // Overflow wraps, carry on cout.
      start8(8'hFF, 8'h01, 1'b0);
      wait8(lat);
      chk("t2_valid", out_valid8, 1);
      chk("t2_sum", sum8, 8'h00);
      chk("t2_cout", cout8, 1);
      @(negedge clk);

      // Carry-in only.
      start8(8'h00, 8'h00, 1'b1);
      wait8(lat);
      chk("t3_valid", out_valid8, 1);
      chk("t3_sum", sum8, 8'h01);
      chk("t3_cout", cout8, 0);
      @(negedge clk);

      // Backpressure: DONE held while out_ready is low.
      out_ready8 = 1'b0;
      start8(8'hA5, 8'h5A, 1'b0);
      wait8(lat);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid8, 1);
         chk("bp_in_ready", in_ready8, 0);
         chk("bp_sum", sum8, 8'hFF);
         chk("bp_cout", cout8, 0);
         @(negedge clk);
      end
      out_ready8 = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid8, 0);
      chk("bp_release_ready", in_ready8, 1);

      // Busy rejection: new operands during SHIFT are ignored.
      start8(8'h03, 8'h04, 1'b0);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("busy_in_ready", in_ready8, 0);
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      wait8(lat);
      chk("busy_valid", out_valid8, 1);
      chk("busy_sum", sum8, 8'h07);
      chk("busy_cout", cout8, 0);
      @(negedge clk);

      // Asynchronous reset three cycles into SHIFT.
      start8(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready8, 1);
      chk("mid_rst_out_valid", out_valid8, 0);
      chk("mid_rst_sum", sum8, 8'h00);
      chk("mid_rst_cout", cout8, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready8, 1);
      chk("post_rst_out_valid", out_valid8, 0);
      start8(8'h80, 8'h80, 1'b0);
      wait8(lat);
      chk("post_rst_latency", lat, 8);
      chk("post_rst_sum", sum8, 8'h00);
      chk("post_rst_cout", cout8, 1);
      @(negedge clk);

      // Exhaustive 4-bit sweep.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               start4(4'(ai), 4'(bi), 1'(ci));
               wait4();
               e4 = 5'(ai + bi + ci);
               chk("sweep_valid", out_valid4, 1);
               chk("sweep_result", {cout4, sum4}, e4);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
